hazard_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle comparator hazard unit.
- Replaces fixed EX/MEM destination compares with a per-register scoreboard of countdown counters, so one block covers:
  - configurable load latency;
  - the branch-register (ID-stage read) distance;
  - store-data forwarding relief;
  - global pipeline freeze.
- Sits beside the ID stage. It produces the ID/IF stall, a stall cause, and a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_sb_entry.sv | 33 +++
 rtl/hazard_scoreboard.sv | 94 +++++++++
 tb/tb_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the scoreboard hazard unit: stall-cause encodings,
// the hardwired-zero register index and the per-register counter width.
package hazard_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_OPERAND = 2'b01,
        CAUSE_BRREG   = 2'b10,
        CAUSE_BOTH    = 2'b11
    } stall_cause_e;

    localparam int ZERO_REG = 0;

    // Width needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage view of the hazard unit: decoded operand/destination info in,
// stall decision and stall-cycle statistic out.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic              id_rs_used;
    logic [REG_AW-1:0] id_rt;
    logic              id_rt_used;
    logic              id_rt_is_sdata;
    logic              id_branch_reg;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_dest;
    logic              id_is_load;
    logic              pipe_freeze;
    logic              flush;
    logic              stall;
    logic [1:0]        stall_cause;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rt_is_sdata,
               id_branch_reg, id_wr_en, id_dest, id_is_load, pipe_freeze, flush,
        input  stall, stall_cause, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rt_is_sdata,
               id_branch_reg, id_wr_en, id_dest, id_is_load, pipe_freeze, flush,
        output stall, stall_cause, stall_cycles
    );
endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: cycles until its register is readable in ID.
// Loadable, counts down to zero, holds while the pipeline is frozen.
module hazard_sb_entry #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_freeze,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: every slot has its own async reset so a falling rst_n clears the
    // hazard (and therefore the stall) without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_freeze) begin
            r_cnt <= r_cnt;
        end else if (i_load) begin
            // NOTE: non-blocking so every slot updates from pre-edge values.
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard unit beside ID: per-register readiness, operand
// and branch-register hazard detection, and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 4,
    parameter int LOAD_LAT  = 1,
    parameter int BR_EXTRA  = 2,
    parameter int STORE_FWD = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int SB_W     = cnt_width(LOAD_LAT + BR_EXTRA);

    localparam logic [SB_W-1:0]   ALU_VAL = SB_W'(BR_EXTRA);
    localparam logic [SB_W-1:0]   LD_VAL  = SB_W'(LOAD_LAT + BR_EXTRA);
    localparam int unsigned       OP_THR  = BR_EXTRA;
    localparam int unsigned       SD_THR  = BR_EXTRA + STORE_FWD;
    localparam logic [REG_AW-1:0] R_ZERO  = REG_AW'(ZERO_REG);

    logic [SB_W-1:0]  w_cnt [NUM_REGS];
    logic [SB_W-1:0]  w_load_val;
    logic             w_issue;
    logic             w_gate;
    logic             w_rs_live;
    logic             w_rt_live;
    logic [31:0]      w_rs_cnt;
    logic [31:0]      w_rt_cnt;
    logic             w_op_haz;
    logic             w_br_haz;
    logic             w_stall;
    stall_cause_e     w_cause;
    logic [CNT_W-1:0] r_stall_cycles;

    assign w_cnt[0]   = '0;
    assign w_issue    = bus.id_valid & ~w_stall & ~bus.pipe_freeze & ~bus.flush;
    assign w_load_val = bus.id_is_load ? LD_VAL : ALU_VAL;

    // The newest producer governs: an issuing write overwrites any pending count.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic w_load;
        assign w_load = w_issue & bus.id_wr_en & (bus.id_dest == REG_AW'(r));

        hazard_sb_entry #(.W(SB_W)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_freeze   (bus.pipe_freeze),
            .i_load     (w_load),
            .i_load_val (w_load_val),
            .o_cnt      (w_cnt[r])
        );
    end

    assign w_gate    = bus.id_valid & ~bus.flush;
    assign w_rs_live = bus.id_rs_used & (bus.id_rs != R_ZERO);
    assign w_rt_live = bus.id_rt_used & (bus.id_rt != R_ZERO);
    assign w_rs_cnt  = 32'(w_cnt[bus.id_rs]);
    assign w_rt_cnt  = 32'(w_cnt[bus.id_rt]);

    // Store data may trail by STORE_FWD extra cycles thanks to MEM-to-MEM forwarding.
    assign w_op_haz = w_gate & (
          (w_rs_live & ~bus.id_branch_reg  & (w_rs_cnt > OP_THR))
        | (w_rt_live & ~bus.id_rt_is_sdata & (w_rt_cnt > OP_THR))
        | (w_rt_live &  bus.id_rt_is_sdata & (w_rt_cnt > SD_THR)));

    assign w_br_haz = w_gate & bus.id_branch_reg & w_rs_live & (w_rs_cnt != 32'd0);
    assign w_stall  = w_op_haz | w_br_haz;

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_op_haz && w_br_haz) w_cause = CAUSE_BOTH;
        else if (w_op_haz)        w_cause = CAUSE_OPERAND;
        else if (w_br_haz)        w_cause = CAUSE_BRREG;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && !bus.pipe_freeze && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign bus.stall        = w_stall;
    assign bus.stall_cause  = w_cause;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: main DUT (STORE_FWD=1, CNT_W=4) plus a
// STORE_FWD=0 copy sharing the same stimulus.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(4), .CNT_W(4))  u_if ();
    hazard_scoreboard_if #(.REG_AW(4), .CNT_W(16)) u_if_nf ();

    assign u_if_nf.id_valid       = u_if.id_valid;
    assign u_if_nf.id_rs          = u_if.id_rs;
    assign u_if_nf.id_rs_used     = u_if.id_rs_used;
    assign u_if_nf.id_rt          = u_if.id_rt;
    assign u_if_nf.id_rt_used     = u_if.id_rt_used;
    assign u_if_nf.id_rt_is_sdata = u_if.id_rt_is_sdata;
    assign u_if_nf.id_branch_reg  = u_if.id_branch_reg;
    assign u_if_nf.id_wr_en       = u_if.id_wr_en;
    assign u_if_nf.id_dest        = u_if.id_dest;
    assign u_if_nf.id_is_load     = u_if.id_is_load;
    assign u_if_nf.pipe_freeze    = u_if.pipe_freeze;
    assign u_if_nf.flush          = u_if.flush;

    hazard_scoreboard #(
        .REG_AW(4), .LOAD_LAT(1), .BR_EXTRA(2), .STORE_FWD(1), .CNT_W(4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    hazard_scoreboard #(
        .REG_AW(4), .LOAD_LAT(1), .BR_EXTRA(2), .STORE_FWD(0), .CNT_W(16)
    ) u_dut_nf (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if_nf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        u_if.id_valid       = 1'b0;
        u_if.id_rs          = '0;
        u_if.id_rs_used     = 1'b0;
        u_if.id_rt          = '0;
        u_if.id_rt_used     = 1'b0;
        u_if.id_rt_is_sdata = 1'b0;
        u_if.id_branch_reg  = 1'b0;
        u_if.id_wr_en       = 1'b0;
        u_if.id_dest        = '0;
        u_if.id_is_load     = 1'b0;
        u_if.pipe_freeze    = 1'b0;
        u_if.flush          = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    // Producer in ID: writes dest, no sources read.
    task automatic producer(input logic [3:0] dest, input logic is_load);
        idle();
        u_if.id_valid   = 1'b1;
        u_if.id_wr_en   = 1'b1;
        u_if.id_dest    = dest;
        u_if.id_is_load = is_load;
    endtask

    // Consumer in ID: reads rs/rt, writes nothing.
    task automatic consumer(input logic [3:0] rs, input logic rs_used,
                            input logic [3:0] rt, input logic rt_used,
                            input logic sdata, input logic br);
        idle();
        u_if.id_valid       = 1'b1;
        u_if.id_rs          = rs;
        u_if.id_rs_used     = rs_used;
        u_if.id_rt          = rt;
        u_if.id_rt_used     = rt_used;
        u_if.id_rt_is_sdata = sdata;
        u_if.id_branch_reg  = br;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        check("reset_stall", u_if.stall, 0);
        check("reset_cause", u_if.stall_cause, 2'b00);
        check("reset_cnt",   u_if.stall_cycles, 0);
        rst_n = 1'b1;
        cycle();

        // Load-use: load r3, then add r6 <- r3.
        producer(4'd3, 1'b1);
        settle();
        check("lu_load_nostall", u_if.stall, 0);
        cycle();
        consumer(4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        u_if.id_wr_en = 1'b1;
        u_if.id_dest  = 4'd6;
        settle();
        check("lu_stall",   u_if.stall, 1);
        check("lu_cause",   u_if.stall_cause, 2'b01);
        cycle();
        check("lu_release", u_if.stall, 0);
        check("lu_cause0",  u_if.stall_cause, 2'b00);
        check("lu_cnt",     u_if.stall_cycles, 1);
        cycle();
        consumer(4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        settle();
        check("alu_fwd_nostall", u_if.stall, 0);
        consumer(4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        settle();
        check("alu_br_cause", u_if.stall_cause, 2'b10);

        // Branch-register after ALU (2 cycles) and after load (3 cycles).
        do_reset();
        producer(4'd5, 1'b0);
        cycle();
        consumer(4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1);
        settle();
        check("br_alu_c2",    u_if.stall_cause, 2'b10);
        cycle();
        check("br_alu_c1",    u_if.stall_cause, 2'b10);
        cycle();
        check("br_alu_ready", u_if.stall, 0);
        cycle();
        producer(4'd5, 1'b1);
        cycle();
        consumer(4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1);
        settle();
        check("br_ld_c3",     u_if.stall_cause, 2'b11);
        cycle();
        check("br_ld_c2",     u_if.stall_cause, 2'b10);
        cycle();
        check("br_ld_c1",     u_if.stall_cause, 2'b10);
        cycle();
        check("br_ld_ready",  u_if.stall, 0);
        check("br_cnt",       u_if.stall_cycles, 5);

        // Store data: load r4 then store r4 (base r0).
        do_reset();
        producer(4'd4, 1'b1);
        cycle();
        consumer(4'd0, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
        settle();
        check("st_fwd_nostall", u_if.stall, 0);
        check("st_nofwd_stall", u_if_nf.stall, 1);
        check("st_nofwd_cause", u_if_nf.stall_cause, 2'b01);
        u_if.id_rt_is_sdata = 1'b0;
        settle();
        check("st_rt_alu_use",  u_if.stall, 1);
        u_if.id_rt_is_sdata = 1'b1;
        cycle();
        check("st_nofwd_ready", u_if_nf.stall, 0);

        // Register zero and unused operands.
        do_reset();
        producer(4'd0, 1'b1);
        cycle();
        consumer(4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        settle();
        check("r0_nostall", u_if.stall, 0);
        producer(4'd3, 1'b1);
        cycle();
        consumer(4'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        settle();
        check("rt_unused_nostall", u_if.stall, 0);
        u_if.id_rt_used = 1'b1;
        settle();
        check("rt_used_stall", u_if.stall, 1);

        // Freeze: c[7] holds at 3 and no stall cycles are counted.
        do_reset();
        producer(4'd7, 1'b1);
        cycle();
        consumer(4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        u_if.pipe_freeze = 1'b1;
        settle();
        check("frz_stall", u_if.stall, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("frz_hold_cause", u_if.stall_cause, 2'b01);
        end
        check("frz_cnt", u_if.stall_cycles, 0);
        u_if.pipe_freeze = 1'b0;
        cycle();
        check("frz_release", u_if.stall, 0);
        check("frz_cnt_after", u_if.stall_cycles, 1);

        // Flush: squashed load never writes; flushed consumer never stalls.
        producer(4'd9, 1'b1);
        u_if.flush = 1'b1;
        cycle();
        consumer(4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        settle();
        check("flush_nowrite", u_if.stall, 0);
        producer(4'd9, 1'b1);
        cycle();
        consumer(4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        u_if.flush = 1'b1;
        settle();
        check("flush_gate", u_if.stall, 0);
        u_if.flush = 1'b0;
        settle();
        check("flush_off_stall", u_if.stall, 1);

        // Reset mid-stall releases asynchronously.
        rst_n = 1'b0;
        #1;
        check("rst_async_stall", u_if.stall, 0);
        check("rst_async_cause", u_if.stall_cause, 2'b00);
        check("rst_async_cnt",   u_if.stall_cycles, 0);
        rst_n = 1'b1;
        idle();
        cycle();

        // Saturation: 8 rounds of 3 stall cycles each with CNT_W=4.
        for (int i = 0; i < 8; i++) begin
            producer(4'd2, 1'b1);
            cycle();
            consumer(4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
            repeat (4) cycle();
            if (i == 3) check("sat_mid", u_if.stall_cycles, 12);
        end
        check("sat_final", u_if.stall_cycles, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
